// File: rtl/nibble_serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bundle for nibble_serial_subtractor.
// o_overflow exists only when SUB_OVERFLOW_EN is defined.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [WIDTH-1:0] i_min;
    logic [WIDTH-1:0] i_sub;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
`ifdef SUB_OVERFLOW_EN
    logic             o_overflow;

    modport master (
        output i_start, i_min, i_sub,
        input  o_busy, o_done, o_diff, o_borrow, o_overflow
    );

    modport slave (
        input  i_start, i_min, i_sub,
        output o_busy, o_done, o_diff, o_borrow, o_overflow
    );
`else
    modport master (
        output i_start, i_min, i_sub,
        input  o_busy, o_done, o_diff, o_borrow
    );

    modport slave (
        input  i_start, i_min, i_sub,
        output o_busy, o_done, o_diff, o_borrow
    );
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: computes min - sub one 4-bit nibble per clock with a registered borrow.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    nibble_serial_subtractor_if.slave bus
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] sub_q, sub_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             res_borrow_q, res_borrow_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W+1:0] lsb;
    logic [4:0]       slice;
`ifdef SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        // NOTE: every variable written here is given its hold value first, so no path infers a latch.
        state_d      = state_q;
        min_d        = min_q;
        sub_d        = sub_q;
        work_d       = work_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        res_borrow_d = res_borrow_q;
        idx_d        = idx_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d        = ovf_q;
`endif
        lsb   = {idx_q, 2'b00};
        slice = {1'b0, min_q[lsb +: 4]} - {1'b0, sub_q[lsb +: 4]} - {4'b0000, borrow_q};

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    min_d    = bus.i_min;
                    sub_d    = bus.i_sub;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                work_d[lsb +: 4] = slice[3:0];
                borrow_d         = slice[4];
                idx_d            = idx_q + 1'b1;
                // Results publish on the same edge the last nibble is written.
                if (idx_q == LAST_IDX) begin
                    state_d      = S_DONE;
                    diff_d       = work_d;
                    res_borrow_d = slice[4];
`ifdef SUB_OVERFLOW_EN
                    ovf_d        = (min_q[WIDTH-1] != sub_q[WIDTH-1]) &&
                                   (work_d[WIDTH-1] != min_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: operand and working registers are cleared too; an aborted operation leaves no trace.
            state_q      <= S_IDLE;
            min_q        <= '0;
            sub_q        <= '0;
            work_q       <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            res_borrow_q <= 1'b0;
            idx_q        <= '0;
`ifdef SUB_OVERFLOW_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            min_q        <= min_d;
            sub_q        <= sub_d;
            work_q       <= work_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            res_borrow_q <= res_borrow_d;
            idx_q        <= idx_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign bus.o_busy     = (state_q == S_RUN);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_diff     = diff_q;
    assign bus.o_borrow   = res_borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign bus.o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: a WIDTH=32 and a WIDTH=4 instance,
// randomized and directed stimulus against an arithmetic reference model.
module tb_nibble_serial_subtractor;

    typedef struct {
        int          dut;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    exp_t        sb[$];
    bit          op_active   [2];
    int          op_start    [2];
    logic [31:0] last_diff   [2];
    logic        last_borrow [2];
    logic        last_ovf    [2];

    logic [31:0] out_diff   [2];
    logic        out_borrow [2];
    logic        out_busy   [2];
    logic        out_done   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_subtractor_if #(.WIDTH(32)) bus32 ();
    nibble_serial_subtractor_if #(.WIDTH(4))  bus4 ();

    nibble_serial_subtractor #(.WIDTH(32)) dut32 (
        .i_clk (clk),
        .i_rst (rst[0]),
        .bus   (bus32)
    );

    nibble_serial_subtractor #(.WIDTH(4)) dut4 (
        .i_clk (clk),
        .i_rst (rst[1]),
        .bus   (bus4)
    );

    assign out_diff[0]   = bus32.o_diff;
    assign out_diff[1]   = {28'd0, bus4.o_diff};
    assign out_borrow[0] = bus32.o_borrow;
    assign out_borrow[1] = bus4.o_borrow;
    assign out_busy[0]   = bus32.o_busy;
    assign out_busy[1]   = bus4.o_busy;
    assign out_done[0]   = bus32.o_done;
    assign out_done[1]   = bus4.o_done;

`ifdef SUB_OVERFLOW_EN
    logic out_ovf [2];
    assign out_ovf[0] = bus32.o_overflow;
    assign out_ovf[1] = bus4.o_overflow;
`endif

    function automatic int steps(int d);
        return (d == 0) ? 8 : 1;
    endfunction

    function automatic int width_of(int d);
        return (d == 0) ? 32 : 4;
    endfunction

    function automatic bit model_busy(int d, int k);
        return op_active[d] && (k > op_start[d]) && (k <= op_start[d] + steps(d));
    endfunction

    // Reference: plain integer arithmetic on the operands seen as unsigned and as signed.
    function automatic exp_t ref_sub(int d, logic [31:0] a, logic [31:0] b, int done_cyc);
        exp_t   e;
        longint span = longint'(1) << width_of(d);
        longint ua   = longint'(a) & (span - 1);
        longint ub   = longint'(b) & (span - 1);
        longint sa   = (ua >= span / 2) ? ua - span : ua;
        longint sbv  = (ub >= span / 2) ? ub - span : ub;
        longint sd   = sa - sbv;
        e.dut      = d;
        e.diff     = 32'((ua - ub + span) % span);
        e.borrow   = (ua < ub);
        e.ovf      = (sd >= span / 2) || (sd < -(span / 2));
        e.done_cyc = done_cyc;
        return e;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_dut(int d);
        string tag      = (d == 0) ? "w32" : "w4";
        bit    exp_busy = model_busy(d, cyc);
        bit    exp_done = op_active[d] && (cyc == op_start[d] + steps(d) + 1);
        bit    has;
        exp_t  e;
        check({tag, "_busy"}, 32'(out_busy[d]), 32'(exp_busy));
        check({tag, "_done"}, 32'(out_done[d]), 32'(exp_done));
        check({tag, "_busy_and_done"}, 32'(out_busy[d] & out_done[d]), 32'd0);
        if (out_done[d] === 1'b1) begin
            has = (sb.size() > 0) && (sb[0].dut == d);
            check({tag, "_done_has_entry"}, 32'(has), 32'd1);
            if (has) begin
                e = sb.pop_front();
                check({tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
                last_diff[d]   = e.diff;
                last_borrow[d] = e.borrow;
                last_ovf[d]    = e.ovf;
            end
        end
        check({tag, "_diff"}, out_diff[d], last_diff[d]);
        check({tag, "_borrow"}, 32'(out_borrow[d]), 32'(last_borrow[d]));
`ifdef SUB_OVERFLOW_EN
        check({tag, "_overflow"}, 32'(out_ovf[d]), 32'(last_ovf[d]));
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) monitor_dut(d);
        end
    end

    task automatic wait_until(int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Called at a falling edge; drives a one-cycle start and predicts whether it is accepted.
    task automatic issue(int d, logic [31:0] a, logic [31:0] b);
        if (d == 0) begin
            bus32.i_start = 1'b1;
            bus32.i_min   = a;
            bus32.i_sub   = b;
        end else begin
            bus4.i_start = 1'b1;
            bus4.i_min   = a[3:0];
            bus4.i_sub   = b[3:0];
        end
        if (!model_busy(d, cyc)) begin
            sb.push_back(ref_sub(d, a, b, cyc + steps(d) + 1));
            op_active[d] = 1'b1;
            op_start[d]  = cyc;
        end
        @(negedge clk);
        if (d == 0) bus32.i_start = 1'b0;
        else        bus4.i_start  = 1'b0;
    endtask

    task automatic finish_op(int d);
        wait_until(op_start[d] + steps(d) + 2);
    endtask

    task automatic pulse_reset(int d);
        rst[d] = 1'b1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].dut == d) sb.delete(i);
        end
        op_active[d]   = 1'b0;
        last_diff[d]   = '0;
        last_borrow[d] = 1'b0;
        last_ovf[d]    = 1'b0;
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    task automatic run_random(int d, int count);
        for (int i = 0; i < count; i++) begin
            issue(d, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) issue(d, $urandom, $urandom);
            wait_until(op_start[d] + steps(d) + 1 + int'($urandom_range(0, 2)));
        end
        finish_op(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus32.i_start = 1'b0;
        bus32.i_min   = '0;
        bus32.i_sub   = '0;
        bus4.i_start  = 1'b0;
        bus4.i_min    = '0;
        bus4.i_sub    = '0;
        for (int d = 0; d < 2; d++) begin
            op_active[d]   = 1'b0;
            op_start[d]    = 0;
            last_diff[d]   = '0;
            last_borrow[d] = 1'b0;
            last_ovf[d]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 2'b00;
        @(negedge clk);

        issue(0, 32'h0000_0005, 32'h0000_0003);
        finish_op(0);
        issue(0, 32'h0000_0000, 32'h0000_0001);
        finish_op(0);
        issue(0, 32'h8000_0000, 32'h0000_0001);
        finish_op(0);
        issue(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        finish_op(0);

        // A start during busy is dropped; a start in the done cycle runs back-to-back.
        issue(0, 32'h0000_0010, 32'h0000_0001);
        wait_until(op_start[0] + 3);
        issue(0, 32'h0000_00FF, 32'h0000_0000);
        wait_until(op_start[0] + 9);
        issue(0, 32'h0000_0020, 32'h0000_0010);
        finish_op(0);

        // Abort mid-operation, then run a fresh one.
        issue(0, 32'h1234_5678, 32'h0F0F_0F0F);
        wait_until(op_start[0] + 4);
        pulse_reset(0);
        issue(0, 32'hDEAD_BEEF, 32'h1234_5678);
        finish_op(0);

        run_random(0, 16);

        issue(1, 32'h3, 32'h5);
        finish_op(1);
        issue(1, 32'h7, 32'hF);
        wait_until(op_start[1] + 1);
        pulse_reset(1);
        issue(1, 32'h8, 32'h1);
        finish_op(1);
        run_random(1, 24);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle unsigned/two's-complement subtractor that computes `i_min - i_sub` one 4-bit nibble per clock, rippling a registered borrow between nibbles. It is the subtraction counterpart to the team's nibble-sliced carry-increment adder. It lets area-constrained datapaths share a single 4-bit slice over `WIDTH/4` cycles, using a start/busy/done handshake. Results are held stable on the outputs until the next operation completes.

## Interface
- `WIDTH`, 32, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- `i_clk`  input  1  clock, all logic on rising edge
- `i_rst`  input  1  synchronous, active-high reset
- `i_start`  input  1  request; sampled only in IDLE or DONE
- `i_min`  input  WIDTH  minuend, captured when start is accepted
- `i_sub`  input  WIDTH  subtrahend, captured when start is accepted
- `o_busy`  output  1  high while nibbles are being processed
- `o_done`  output  1  one-cycle pulse, result valid and newly updated
- `o_diff`  output  WIDTH  registered difference, `(i_min - i_sub) mod 2^WIDTH`
- `o_borrow`  output  1  final borrow-out; 1 iff `i_min < i_sub` unsigned
- `o_overflow`  output  1  signed overflow; present only with `SUB_OVERFLOW_EN`

## Operation
- `N = WIDTH/4` nibble steps per operation.
- Internal state: operand registers, working difference register, borrow flop, nibble index counter of `clog2(N)` bits (minimum 1 bit), and a 3-state FSM: IDLE, RUN, DONE.
- **IDLE:**
  - `i_start=1`: capture `i_min`/`i_sub`, clear borrow and index, go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** each cycle, for nibble `j` = index:
  - `{b, d} = min[4j+3:4j] - sub[4j+3:4j] - borrow`, computed as a 5-bit subtraction.
  - Write `d` into working nibble `j`, set borrow ← `b`, index ← index + 1.
  - `i_start` is ignored.
- **Last nibble (index = N-1):** go to DONE on the same edge.
  - `o_diff` ← full working result, with nibble N-1 included.
  - `o_borrow` ← final `b`.
  - `o_overflow` ← `(min[W-1] ≠ sub[W-1]) & (diff[W-1] ≠ min[W-1])`.
- **DONE:** `o_done=1` for exactly this cycle.
  - `i_start=1`: capture new operands and go directly to RUN (back-to-back).
  - Otherwise go to IDLE.
- `o_diff`, `o_borrow` and `o_overflow` change only on the transition into DONE, and hold between operations.
- Reset, including mid-RUN: FSM → IDLE, all internal registers and all outputs → 0, no `o_done` pulse. The operation in progress is discarded.

## Timing
- `i_start` is high in cycle c and accepted:
  - `o_busy`=1 in cycles c+1 … c+N.
  - `o_done`=1 in cycle c+N+1.
  - Result is valid from cycle c+N+1 onward.
- WIDTH=32: 8 busy cycles; done in c+9.
- Throughput with back-to-back starts: one result every N+1 cycles.
- `o_busy` and `o_done` are never high in the same cycle.
- Outputs are fully registered; no combinational path from inputs to outputs.
- Reset values: `o_busy`=0, `o_done`=0, `o_diff`=0, `o_borrow`=0, `o_overflow`=0.

## Configuration
- `SUB_OVERFLOW_EN` defined:
  - Port `o_overflow` and its register exist.
  - Updated at the DONE transition per the formula above; reset to 0.
- `SUB_OVERFLOW_EN` not defined:
  - `o_overflow` port and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
- WIDTH=32, `0x0000_0005 - 0x0000_0003`:
  - `o_diff`=0x0000_0002, `o_borrow`=0.
  - `o_busy` high c+1..c+8; `o_done` only in c+9.
- `0x0000_0000 - 0x0000_0001`:
  - Borrow ripples through all 8 nibbles.
  - `o_diff`=0xFFFF_FFFF, `o_borrow`=1, `o_overflow`=0.
- With `SUB_OVERFLOW_EN`, `0x8000_0000 - 0x0000_0001`:
  - `o_diff`=0x7FFF_FFFF, `o_borrow`=0, `o_overflow`=1.
  - Then `0x7FFF_FFFF - 0xFFFF_FFFF`: `o_diff`=0x8000_0000, `o_borrow`=1, `o_overflow`=1.
- Start `0x10 - 0x01`; pulse `i_start` with `0xFF - 0x00` during busy:
  - The busy-time start is ignored; result 0x0000_000F.
  - Start `0x20 - 0x10` during the `o_done` cycle: accepted; second done exactly 9 cycles later with 0x0000_0010.
- Assert `i_rst` in cycle c+4 of an operation:
  - Next cycle: all outputs 0, IDLE.
  - No `o_done` follows.
  - A fresh start then completes normally.
- WIDTH=4 instance, `0x3 - 0x5`:
  - `o_diff`=0xE, `o_borrow`=1.
  - Busy in c+1 only; done in c+2.
